// File: rtl/lab_pkg.sv
// Shared definitions for the sequencer labs: FSM encodings, counter sizing
// helpers and the parameter-legality check used at elaboration.
package lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_HOLD,
        ST_REPEAT
    } btn_state_e;

    typedef enum logic [1:0] {
        SEQ_S0,
        SEQ_S1,
        SEQ_S2,
        SEQ_S3
    } seq_state_e;

    function automatic int ctr_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

    // Pulse spacing below 2 would merge adjacent strobes into one long high.
    function automatic int min2(input int cycles);
        return (cycles < 2) ? 2 : cycles;
    endfunction

    function automatic bit params_legal(
        input int sync_stages,
        input int debounce_cycles,
        input int repeat_en,
        input int repeat_delay,
        input int repeat_period
    );
        return (sync_stages >= 2) && (sync_stages <= 4) &&
               (debounce_cycles >= 1) &&
               ((repeat_en == 0) || (repeat_en == 1)) &&
               (repeat_delay >= 1) && (repeat_period >= 1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Input synchronizer plus debounce counter. dout leads the top-level pressed
// register by one cycle so the enable strobe can be registered on the same edge.
module debounce_filter
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int            CW       = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (level != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = level;
            end else begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values and the shift chain cannot collapse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/button_enable_gen.sv
// Debounced pushbutton to one-cycle enable strobe, with optional auto-repeat
// while held. Release always wins over a repeat pulse due on the same edge.
module button_enable_gen
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pressed,
    output logic enable
);

    localparam int DELAY_EFF  = min2(REPEAT_DELAY);
    localparam int PERIOD_EFF = min2(REPEAT_PERIOD);
    localparam int TW = ctr_width((DELAY_EFF > PERIOD_EFF) ? DELAY_EFF : PERIOD_EFF);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(DELAY_EFF - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_EFF - 1);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD))
    begin : g_param_check
        $error("button_enable_gen: illegal parameter combination");
    end

    btn_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          pressed_q, enable_q, enable_d;
    logic          level, rise, fall;

    debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clk  (clk),
        .reset(reset),
        .din  (btn),
        .dout (level)
    );

    assign rise      = level & ~pressed_q;
    assign fall      = ~level & pressed_q;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    // timer_q counts edges since the last enable pulse.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_inc;
        enable_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rise) begin
                    state_d  = ST_FIRST;
                    enable_d = 1'b1;
                end
            end
            ST_FIRST: begin
                state_d = fall ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if ((REPEAT_EN != 0) && (timer_q == DELAY_LAST)) begin
                    state_d  = ST_REPEAT;
                    enable_d = 1'b1;
                    timer_d  = '0;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (timer_q == PERIOD_LAST) begin
                    enable_d = 1'b1;
                    timer_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pressed_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pressed_q <= level;
            enable_q  <= enable_d;
        end
    end

    assign pressed = pressed_q;
    assign enable  = enable_q;

endmodule

// File: tb/tb_button_enable_gen.sv
// Directed bench for button_enable_gen: three configurations share btn/reset,
// expected enable edges and sequencer states are queued and popped as they occur.
module tb_button_enable_gen;
    import lab_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int PER  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic btn   = 1'b0;
    logic pressed0, enable0, pressed1, enable1, pressed2, enable2;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    int         exp0[$];
    int         exp1[$];
    int         exp2[$];
    seq_state_e seq_exp[$];
    seq_state_e seq_q    = SEQ_S0;
    seq_state_e seq_prev = SEQ_S0;
    logic       prev_en0 = 1'b0;
    logic       prev_en1 = 1'b0;
    logic       prev_en2 = 1'b0;
    bit         due0, due1, due2;
    logic [31:0] exp_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_enable_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
                        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
        u_dut0 (.clk(clk), .reset(reset), .btn(btn), .pressed(pressed0), .enable(enable0));

    button_enable_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
                        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
        u_dut1 (.clk(clk), .reset(reset), .btn(btn), .pressed(pressed1), .enable(enable1));

    button_enable_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
                        .REPEAT_DELAY(1), .REPEAT_PERIOD(1))
        u_dut2 (.clk(clk), .reset(reset), .btn(btn), .pressed(pressed2), .enable(enable2));

    // Downstream sequencer: one enable walks S0 -> S1 -> S2 -> S3 -> S0.
    always @(posedge clk) begin
        if (reset) seq_q <= SEQ_S0;
        else begin
            case (seq_q)
                SEQ_S0:  if (enable0 === 1'b1) seq_q <= SEQ_S1;
                SEQ_S1:  seq_q <= SEQ_S2;
                SEQ_S2:  seq_q <= SEQ_S3;
                default: seq_q <= SEQ_S0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pressed0"}, pressed0, 0);
        check({tag, "_pressed1"}, pressed1, 0);
        check({tag, "_pressed2"}, pressed2, 0);
        check({tag, "_enable0"},  enable0,  0);
        check({tag, "_enable1"},  enable1,  0);
        check({tag, "_enable2"},  enable2,  0);
    endtask

    task automatic push_seq();
        seq_exp.push_back(SEQ_S1);
        seq_exp.push_back(SEQ_S2);
        seq_exp.push_back(SEQ_S3);
        seq_exp.push_back(SEQ_S0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        due0 = (exp0.size() != 0) && (exp0[0] == cyc);
        due1 = (exp1.size() != 0) && (exp1[0] == cyc);
        due2 = (exp2.size() != 0) && (exp2[0] == cyc);
        if (due0 || enable0 !== 1'b0) check("enable0", enable0, due0);
        if (due1 || enable1 !== 1'b0) check("enable1", enable1, due1);
        if (due2 || enable2 !== 1'b0) check("enable2", enable2, due2);
        if (due0) void'(exp0.pop_front());
        if (due1) void'(exp1.pop_front());
        if (due2) void'(exp2.pop_front());
        if (enable0 === 1'b1) check("enable0_gap", prev_en0, 0);
        if (enable1 === 1'b1) check("enable1_gap", prev_en1, 0);
        if (enable2 === 1'b1) check("enable2_gap", prev_en2, 0);
        prev_en0 = enable0;
        prev_en1 = enable1;
        prev_en2 = enable2;
        if (seq_q !== seq_prev) begin
            exp_s = (seq_exp.size() != 0) ? 32'(seq_exp.pop_front()) : 32'hFFFF_FFFF;
            check("seq_state", seq_q, exp_s);
            seq_prev = seq_q;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        to_cyc(2);
        check_all_zero("reset");
        reset = 1'b0;

        // Clean press held 30 cycles (btn sampled high at edges 10..39).
        exp0.push_back(16);
        exp1.push_back(16); exp1.push_back(36); exp1.push_back(44);
        for (int e = 16; e <= 44; e += 2) exp2.push_back(e);
        push_seq();
        to_cyc(9);  btn = 1'b1;
        to_cyc(15); check("clean_pressed_before", pressed0, 0);
        to_cyc(16); check("clean_pressed_rise", pressed0, 1);
                    check("clean_pressed1_rise", pressed1, 1);
        to_cyc(39); btn = 1'b0;
        to_cyc(45); check("clean_pressed_held", pressed0, 1);
        to_cyc(46); check("clean_release0", pressed0, 0);
                    check("clean_release1", pressed1, 0);
                    check("clean_release2", pressed2, 0);

        // Bounce: 2-cycle toggles over edges 60..71, stable high from 72.
        exp0.push_back(78);
        exp1.push_back(78); exp1.push_back(98);
        for (int e = 78; e <= 104; e += 2) exp2.push_back(e);
        push_seq();
        for (int i = 0; i < 3; i++) begin
            to_cyc(59 + 4 * i); btn = 1'b1;
            to_cyc(61 + 4 * i); btn = 1'b0;
        end
        to_cyc(71);  btn = 1'b1;
        to_cyc(75);  check("bounce_pressed_mid", pressed0, 0);
        to_cyc(77);  check("bounce_pressed_before", pressed0, 0);
        to_cyc(78);  check("bounce_pressed_rise", pressed0, 1);
        to_cyc(99);  btn = 1'b0;
        to_cyc(105); check("bounce_pressed1_held", pressed1, 1);
        to_cyc(106); check("bounce_release1", pressed1, 0);

        // Glitch: three high samples at edges 120..122.
        to_cyc(119); btn = 1'b1;
        to_cyc(122); btn = 1'b0;
        to_cyc(126); check_all_zero("glitch_a");
        to_cyc(132); check_all_zero("glitch_b");

        // Repeat: btn sampled high at edges 150..209.
        exp0.push_back(156);
        exp1.push_back(156); exp1.push_back(176); exp1.push_back(184);
        exp1.push_back(192); exp1.push_back(200); exp1.push_back(208);
        for (int e = 156; e <= 214; e += 2) exp2.push_back(e);
        push_seq();
        to_cyc(149); btn = 1'b1;
        to_cyc(209); btn = 1'b0;
        to_cyc(215); check("repeat_pressed_held", pressed1, 1);
        to_cyc(216); check("repeat_release", pressed1, 0);

        // Reset mid-hold at edges 280..281, btn still high afterwards.
        exp0.push_back(256); exp0.push_back(288);
        exp1.push_back(256); exp1.push_back(276); exp1.push_back(288);
        for (int e = 256; e <= 278; e += 2) exp2.push_back(e);
        for (int e = 288; e <= 304; e += 2) exp2.push_back(e);
        push_seq();
        push_seq();
        to_cyc(249); btn = 1'b1;
        to_cyc(279); reset = 1'b1;
        to_cyc(280); check_all_zero("midreset_a");
        to_cyc(281); check_all_zero("midreset_b");
        reset = 1'b0;
        to_cyc(287); check("rearm_pressed_before", pressed0, 0);
        to_cyc(288); check("rearm_pressed_rise", pressed0, 1);
        to_cyc(299); btn = 1'b0;
        to_cyc(306); check("rearm_release", pressed0, 0);

        to_cyc(320);
        check("exp0_left", exp0.size(), 0);
        check("exp1_left", exp1.size(), 0);
        check("exp2_left", exp2.size(), 0);
        check("seq_left", seq_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
